// File: rtl/bus_switch_arbiter_if.sv
// bus_switch_arbiter_if: request/gate-drive bundle between requesters and the switch arbiter
// req: per-requester tenure request; gate_n/gate_p: complementary pass-gate drives;
// owner: index of the granted requester; busy: a pass gate is on.
interface bus_switch_arbiter_if #(parameter int N_REQ = 4);
   localparam int W = N_REQ > 1 ? $clog2(N_REQ) : 1;
   logic [N_REQ-1:0] req;
   logic [N_REQ-1:0] gate_n;
   logic [N_REQ-1:0] gate_p;
   logic [W-1:0] owner;
   logic busy;
   modport master (output req, input gate_n, gate_p, owner, busy);
   modport slave (input req, output gate_n, gate_p, owner, busy);
endinterface

// File: rtl/bus_switch_arbiter.sv
// bus_switch_arbiter: round-robin owner of a shared switched bus node with break-before-make dead time
// Ports: clk, rst (sync, active-high), bus (slave modport: req in; gate_n, gate_p, owner, busy out).
module bus_switch_arbiter #(
   parameter int N_REQ = 4,
   parameter int DEAD_CYCLES = 2,
   parameter int MAX_HOLD = 8
) (
   input logic clk,
   input logic rst,
   bus_switch_arbiter_if.slave bus
);
   localparam int W = N_REQ > 1 ? $clog2(N_REQ) : 1;
   typedef enum logic [1:0] {IDLE, ON, DEAD} state_t;
   state_t state;
   logic [W-1:0] ptr, win, cand;
   logic [7:0] hold_cnt;
   logic [3:0] dead_cnt;
   logic [N_REQ-1:0] others;
   logic any_req, hold_max, leave, arb;
   int idx;
   // Scan from the highest offset down so the requester closest to ptr wins last.
   always_comb begin
      win = ptr;
      cand = ptr;
      idx = 0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         cand = W'(idx);
         if (bus.req[cand]) win = cand;
      end
   end
   assign others = bus.req & ~(N_REQ'(1) << bus.owner);
   assign any_req = |bus.req;
   assign hold_max = hold_cnt == 8'(MAX_HOLD - 1);
   assign leave = !bus.req[bus.owner] || (hold_max && |others);
   // Arbitration happens from IDLE or on the last dead cycle, so no extra gap follows reset.
   assign arb = (state == IDLE || (state == DEAD && dead_cnt == '0)) && any_req;
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         bus.gate_n <= '0;
         bus.gate_p <= '1;
         bus.owner <= '0;
         bus.busy <= 1'b0;
         ptr <= '0;
         hold_cnt <= '0;
         dead_cnt <= '0;
      end else if (arb) begin
         state <= ON;
         bus.gate_n <= N_REQ'(1) << win;
         bus.gate_p <= ~(N_REQ'(1) << win);
         bus.owner <= win;
         bus.busy <= 1'b1;
         hold_cnt <= '0;
      end else if (state == DEAD) begin
         if (dead_cnt == '0) state <= IDLE;
         else dead_cnt <= dead_cnt - 4'd1;
      end else if (state == ON) begin
         hold_cnt <= hold_max ? hold_cnt : hold_cnt + 8'd1;
         if (leave) begin
            state <= DEAD;
            bus.gate_n <= '0;
            bus.gate_p <= '1;
            bus.owner <= '0;
            bus.busy <= 1'b0;
            ptr <= bus.owner == W'(N_REQ - 1) ? '0 : bus.owner + 1'b1;
            dead_cnt <= 4'(DEAD_CYCLES - 1);
         end
      end
   end
endmodule

// File: tb/tb_bus_switch_arbiter.sv
// tb_bus_switch_arbiter: scoreboard bench for bus_switch_arbiter with directed vectors and random traffic
module tb_bus_switch_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   bus_switch_arbiter_if #(.N_REQ(4)) ifc();
   bus_switch_arbiter #(.N_REQ(4), .DEAD_CYCLES(2), .MAX_HOLD(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
   always #5 clk = ~clk;
   typedef struct {
      logic [3:0] g;
      logic [1:0] o;
      logic b;
      string nm;
   } exp_t;
   exp_t q[$];
   exp_t e;
   int n_chk = 0;
   int n_fail = 0;
   bit rnd_on = 1'b0;
   bit seen = 1'b0;
   logic [3:0] last = '0;
   int zr = 0;
   task automatic step(input logic [3:0] r, input logic rs, input logic [3:0] g, input logic [1:0] o, input string nm);
      ifc.req = r;
      rst = rs;
      @(posedge clk);
      q.push_back('{g, o, |g, nm});
      #1;
   endtask
   always @(negedge clk) begin
      if (q.size() > 0) begin
         e = q.pop_front();
         n_chk++;
         if ({ifc.gate_n, ifc.gate_p, ifc.owner, ifc.busy} !== {e.g, ~e.g, e.o, e.b}) begin
            n_fail++;
            $display("FAIL %s: got gate_n=%b gate_p=%b owner=%0d busy=%b, expected gate_n=%b gate_p=%b owner=%0d busy=%b",
                     e.nm, ifc.gate_n, ifc.gate_p, ifc.owner, ifc.busy, e.g, ~e.g, e.o, e.b);
         end
      end
      if (rnd_on) begin
         n_chk++;
         if ($countones(ifc.gate_n) > 1 || ifc.gate_p !== ~ifc.gate_n) begin
            n_fail++;
            $display("FAIL rnd_onehot_inv: got gate_n=%b gate_p=%b, expected at most one bit and gate_p=~gate_n", ifc.gate_n, ifc.gate_p);
         end
         if (ifc.gate_n == '0) zr++;
         else begin
            if (seen && ifc.gate_n != last) begin
               n_chk++;
               if (zr < 2) begin
                  n_fail++;
                  $display("FAIL rnd_gap: got %0d zero cycles between %b and %b, expected at least 2", zr, last, ifc.gate_n);
               end
            end
            last = ifc.gate_n;
            seen = 1'b1;
            zr = 0;
         end
      end
   end
   initial begin
      #2000000;
      $display("FAIL watchdog: got no end of stimulus, expected completion");
      $fatal(1);
   end
   initial begin
      ifc.req = '0;
      step(4'b0000, 1, 4'b0000, 0, "reset");
      step(4'b0000, 1, 4'b0000, 0, "reset");
      step(4'b0001, 0, 4'b0001, 0, "grant0");
      repeat (3) step(4'b0101, 0, 4'b0001, 0, "hold0");
      step(4'b0100, 0, 4'b0000, 0, "dead_a");
      step(4'b0100, 0, 4'b0000, 0, "dead_b");
      step(4'b0100, 0, 4'b0100, 2, "grant2");
      step(4'b0000, 0, 4'b0000, 0, "rel_a");
      step(4'b0000, 0, 4'b0000, 0, "rel_b");
      step(4'b0000, 0, 4'b0000, 0, "idle");
      step(4'b1001, 0, 4'b1000, 3, "grant3_from_ptr3");
      repeat (2) step(4'b1001, 0, 4'b1000, 3, "hold3");
      step(4'b1001, 1, 4'b0000, 0, "rst_mid_on");
      step(4'b1001, 0, 4'b0001, 0, "grant_after_rst");
      step(4'b0000, 1, 4'b0000, 0, "reset_solo");
      for (int c = 0; c < 30; c++) step(4'b0010, 0, 4'b0010, 1, "solo_no_preempt");
      step(4'b0000, 1, 4'b0000, 0, "reset_rr");
      for (int p = 0; p < 5; p++) begin
         for (int c = 0; c < 8; c++) step(4'b1111, 0, 4'(1 << (p % 4)), 2'(p % 4), "rr_hold");
         if (p < 4) repeat (2) step(4'b1111, 0, 4'b0000, 0, "rr_gap");
      end
      rnd_on = 1'b1;
      for (int c = 0; c < 10000; c++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) ifc.req[b] = ~ifc.req[b];
         @(posedge clk);
         #1;
      end
      rnd_on = 1'b0;
      @(negedge clk);
      #1;
      n_chk++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_switch_arbiter.md
BUS_SWITCH_ARBITER -- requirements
Module: bus_switch_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one switched bus node.
REQ-002 The block SHALL have parameter DEAD_CYCLES, default 2, giving the all-switches-off gap between owners; legal range 1..15.
REQ-003 The block SHALL have parameter MAX_HOLD, default 8, giving the grant cycles before preemption when others wait; legal range 1..255.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req  input  N_REQ  per-requester request; held high for the whole bus tenure.
REQ-007 gate_n  output  N_REQ  registered nmos gate drive; bit i high = requester i's pass gate on (equals grant).
REQ-008 gate_p  output  N_REQ  registered pmos gate drive; always the bitwise inverse of gate_n.
REQ-009 owner  output  clog2(N_REQ)  index of the current owner; 0 when busy=0.
REQ-010 busy  output  1  high when any gate_n bit is high.

Function
REQ-011 The block SHALL implement states IDLE, ON and DEAD; gate_n SHALL be all-zero in IDLE and DEAD.
REQ-012 IDLE, no req bit high: remain IDLE.
REQ-013 IDLE, any req bit high: pick a winner round-robin from pointer ptr upward (wrapping at N_REQ), enter ON, set gate_n one-hot at the winner, clear hold_cnt; grant latency SHALL be exactly 1 cycle.
REQ-014 ON: hold_cnt SHALL increment each cycle, saturating at MAX_HOLD-1.
REQ-015 ON, req[owner]=0: enter DEAD next edge, with gate_n all-zero on that edge.
REQ-016 ON, hold_cnt=MAX_HOLD-1 and any other req bit high: preempt by entering DEAD; the preempted requester's req may stay high and it re-arbitrates normally.
REQ-017 ON, hold_cnt=MAX_HOLD-1 and no other req bit high: keep the grant indefinitely.
REQ-018 On every ON->DEAD transition, ptr SHALL become (owner+1) mod N_REQ.
REQ-019 DEAD SHALL last exactly DEAD_CYCLES cycles, counted by a down-counter loaded with DEAD_CYCLES-1 on entry.
REQ-020 DEAD with counter=0: if any req bit is high, arbitrate as in REQ-013 and enter ON directly; otherwise enter IDLE.
REQ-021 Between any two non-zero gate_n values, the all-zero gap SHALL be exactly DEAD_CYCLES cycles when a request is pending at the end of DEAD.
REQ-022 popcount(gate_n) SHALL never exceed 1.
REQ-023 gate_p SHALL equal ~gate_n in every cycle, including reset.
REQ-024 A req bit rising and falling while DEAD is active SHALL be ignored unless it is high at the arbitration edge.
REQ-025 A req bit dropping at the same edge it would win arbitration SHALL not be granted, because arbitration samples req at that edge.
REQ-026 An owner that drops and re-raises req SHALL compete again only after DEAD, at priority per ptr.

Reset
REQ-027 With rst high at an edge: state IDLE, gate_n=0, gate_p all-ones, owner=0, busy=0, ptr=0, hold_cnt=0, dead counter=0.
REQ-028 rst SHALL override all other inputs, including mid-ON and mid-DEAD.
REQ-029 After reset, no dead time SHALL be inserted before the first grant, because all gates are already off.

Verification (N_REQ=4, DEAD_CYCLES=2, MAX_HOLD=8)
REQ-030 The bench SHALL check: reset, then req=0001 at cycle 0 -> gate_n=0001, gate_p=1110, owner=0, busy=1 at cycle 1.
REQ-031 The bench SHALL check: owner 0 holding, req=0101, then req[0] drops -> gate_n=0000 for exactly 2 cycles, then gate_n=0100, owner=2.
REQ-032 The bench SHALL check: req=1111 held constantly -> gate_n cycles 0001, 0010, 0100, 1000, 0001, each for 8 cycles, separated by 2 all-zero cycles.
REQ-033 The bench SHALL check: req=0010 alone held for 30 cycles -> gate_n=0010 continuously, with no preemption.
REQ-034 The bench SHALL check: rst pulsed during ON with owner=3 -> next cycle gate_n=0000, gate_p=1111, ptr=0; with req=1001 after reset -> gate_n=0001 one cycle later.
REQ-035 The bench SHALL assert in every cycle of random req traffic (10k cycles): popcount(gate_n)<=1, gate_p==~gate_n, and at least 2 all-zero cycles between differing non-zero gate_n values.
